// File: rtl/ub_seq_pkg.sv
// rtl/ub_seq_pkg.sv - shared types and constants for the unified buffer sequencer
//
// Purpose: command opcode and FSM state encodings, tile geometry and the
// default unified buffer depth used by ub_sequencer and ub_range_check.
package ub_seq_pkg;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } ub_op_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_STORE_WAIT = 3'd2,
    ST_STORE      = 3'd3,
    ST_FINISH     = 3'd4
  } ub_state_e;

  localparam int UB_TILE_WORDS        = 4;
  localparam int UB_MEM_DEPTH_DEFAULT = 64;

endpackage

// File: rtl/ub_sequencer_if.sv
// rtl/ub_sequencer_if.sv - command, unified buffer, accumulator and input setup signals
//
// Purpose: bundles every non-clock/reset signal of ub_sequencer.
// Modports:
//   master - the sequencer: drives cmd_ready, ub_*, acc_ack, tile_valid,
//            busy, done, cmd_error; samples command fields and the
//            accumulator / input setup handshakes.
//   slave  - the environment around the sequencer (mirror image).
interface ub_sequencer_if #(
  parameter int ADDR_W   = 13,
  parameter int CNT_W    = 8,
  parameter int STRIDE_W = 8
) ();

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_op;
  logic [ADDR_W-1:0]   cmd_base;
  logic [CNT_W-1:0]    cmd_count;
  logic [STRIDE_W-1:0] cmd_stride;

  logic [ADDR_W-1:0]   ub_addr;
  logic                ub_load_input;
  logic                ub_store;

  logic                store_acc1;
  logic                store_acc2;
  logic                acc_ack;

  logic                isb_ready;
  logic                tile_valid;

  logic                busy;
  logic                done;
  logic                cmd_error;

  modport master (
    input  cmd_valid, cmd_op, cmd_base, cmd_count, cmd_stride,
    input  store_acc1, store_acc2, isb_ready,
    output cmd_ready, ub_addr, ub_load_input, ub_store,
    output acc_ack, tile_valid, busy, done, cmd_error
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_base, cmd_count, cmd_stride,
    output store_acc1, store_acc2, isb_ready,
    input  cmd_ready, ub_addr, ub_load_input, ub_store,
    input  acc_ack, tile_valid, busy, done, cmd_error
  );

endinterface

// File: rtl/ub_range_check.sv
// rtl/ub_range_check.sv - last-word address compute and bounds compare for a command
//
// Purpose: combinational check of whether a command's final tile word
// (base + stride*(count-1) + UB_TILE_WORDS-1) lies inside the buffer.
// Ports:
//   base, count, stride  in   command fields
//   zero_count           out  count is 0 (command is a no-op)
//   out_of_range         out  count != 0 and last word > MEM_DEPTH-1
module ub_range_check
  import ub_seq_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int CNT_W     = 8,
  parameter int STRIDE_W  = 8,
  parameter int MEM_DEPTH = UB_MEM_DEPTH_DEFAULT
) (
  input  logic [ADDR_W-1:0]   base,
  input  logic [CNT_W-1:0]    count,
  input  logic [STRIDE_W-1:0] stride,
  output logic                zero_count,
  output logic                out_of_range
);

  // Wide enough that base + stride*(count-1) + 3 can never truncate.
  localparam int W = ADDR_W + CNT_W + STRIDE_W;

  logic [CNT_W-1:0] cnt_m1;
  logic [W-1:0]     last_addr;

  always_comb begin
    zero_count = (count == '0);
    // Wraps to all-ones when count is 0; the result is masked by zero_count.
    cnt_m1     = count - CNT_W'(1);
    last_addr  = W'(base) + (W'(stride) * W'(cnt_m1)) + W'(UB_TILE_WORDS - 1);
    out_of_range = !zero_count && (last_addr > W'(MEM_DEPTH - 1));
  end

endmodule

// File: rtl/ub_sequencer.sv
// rtl/ub_sequencer.sv - command-driven sequencer for all unified buffer accesses
//
// Purpose: accepts one LOAD or STORE command of N four-word tiles at a time.
// LOAD streams tiles from the unified buffer toward the input setup buffer,
// one per cycle while isb_ready is high. STORE writes one tile per
// accumulator pair handoff, waiting for both full flags each time.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   bus          ub_sequencer_if.master: command channel, unified buffer
//                addr/strobes, accumulator flags/ack, input setup
//                ready/tile_valid, busy/done/cmd_error status
module ub_sequencer
  import ub_seq_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int MEM_DEPTH = UB_MEM_DEPTH_DEFAULT,
  parameter int CNT_W     = 8,
  parameter int STRIDE_W  = 8
) (
  input  logic          clk,
  input  logic          reset,
  ub_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE       = ST_IDLE;
  localparam logic [2:0] S_LOAD       = ST_LOAD;
  localparam logic [2:0] S_STORE_WAIT = ST_STORE_WAIT;
  localparam logic [2:0] S_STORE      = ST_STORE;
  localparam logic [2:0] S_FINISH     = ST_FINISH;

  logic [2:0]          state;
  logic [ADDR_W-1:0]   cur;
  logic [CNT_W-1:0]    remaining;
  logic [STRIDE_W-1:0] stride;
  logic                tile_valid_q;
  logic                done_zero_q;
  logic                cmd_error_q;

  logic                zero_count;
  logic                out_of_range;
  logic                load_fire;
  logic                store_fire;
  logic                last_tile;

  ub_range_check #(
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .STRIDE_W (STRIDE_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_range_check (
    .base        (bus.cmd_base),
    .count       (bus.cmd_count),
    .stride      (bus.cmd_stride),
    .zero_count  (zero_count),
    .out_of_range(out_of_range)
  );

  // The load strobe follows isb_ready in the same cycle so tiles can
  // stream back to back; the store strobe is purely state-based.
  assign load_fire  = (state == S_LOAD) && bus.isb_ready;
  assign store_fire = (state == S_STORE);
  assign last_tile  = (remaining == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cur          <= '0;
      remaining    <= '0;
      stride       <= '0;
      tile_valid_q <= 1'b0;
      done_zero_q  <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      // Buffer read latency is one cycle, so tile_valid trails the strobe.
      tile_valid_q <= load_fire;
      done_zero_q  <= 1'b0;
      cmd_error_q  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            if (out_of_range) begin
              cmd_error_q <= 1'b1;
            end else if (zero_count) begin
              done_zero_q <= 1'b1;
            end else begin
              cur       <= bus.cmd_base;
              remaining <= bus.cmd_count;
              stride    <= bus.cmd_stride;
              state     <= (bus.cmd_op == OP_STORE) ? S_STORE_WAIT : S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (bus.isb_ready) begin
            cur       <= cur + ADDR_W'(stride);
            remaining <= remaining - CNT_W'(1);
            if (last_tile) begin
              state <= S_FINISH;
            end
          end
        end

        S_STORE_WAIT: begin
          if (bus.store_acc1 && bus.store_acc2) begin
            state <= S_STORE;
          end
        end

        S_STORE: begin
          cur       <= cur + ADDR_W'(stride);
          remaining <= remaining - CNT_W'(1);
          state     <= last_tile ? S_FINISH : S_STORE_WAIT;
        end

        S_FINISH: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.cmd_ready     = (state == S_IDLE);
    bus.ub_load_input = load_fire;
    bus.ub_store      = store_fire;
    bus.acc_ack       = store_fire;
    bus.ub_addr       = (load_fire || store_fire) ? cur : '0;
    bus.tile_valid    = tile_valid_q;
    bus.busy          = (state == S_LOAD) || (state == S_STORE_WAIT) ||
                        (state == S_STORE);
    bus.done          = (state == S_FINISH) || done_zero_q;
    bus.cmd_error     = cmd_error_q;
  end

endmodule

// File: tb/tb_ub_sequencer.sv
// tb/tb_ub_sequencer.sv - self-checking bench for ub_sequencer
module tb_ub_sequencer;
  import ub_seq_pkg::*;

  localparam int ADDR_W    = 13;
  localparam int CNT_W     = 8;
  localparam int STRIDE_W  = 8;
  localparam int MEM_DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ub_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .STRIDE_W(STRIDE_W)) bus ();

  ub_sequencer #(
    .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W), .STRIDE_W(STRIDE_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor and unified buffer data model ----------------
  int          load_q[$];
  int          store_q[$];
  int          n_tv, n_done, n_err, n_ack, n_done_tv, n_busy;
  bit          ready_low;
  bit          mon_en = 0;
  bit          prev_load = 0;
  bit          prev_reset = 1;
  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] staged [4];
  logic [31:0] cap [4];

  task automatic clear_mon();
    load_q.delete();
    store_q.delete();
    n_tv = 0; n_done = 0; n_err = 0; n_ack = 0; n_done_tv = 0; n_busy = 0;
    ready_low = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("excl_strobes", 64'(bus.ub_load_input & bus.ub_store), 0);
      check("addr_zero_idle",
            (bus.ub_load_input | bus.ub_store) ? 64'd0 : 64'(bus.ub_addr), 0);
      check("tile_valid_latency", 64'(bus.tile_valid), 64'(prev_load & ~prev_reset));
      check("ack_with_store", 64'(bus.acc_ack), 64'(bus.ub_store));
      if (bus.tile_valid) cap = staged;
      if (bus.ub_load_input) begin
        load_q.push_back(int'(bus.ub_addr));
        for (int k = 0; k < 4; k++) begin
          int a;
          a = int'(bus.ub_addr) + k;
          staged[k] = (a < MEM_DEPTH) ? mem[a] : 32'd0;
        end
      end
      if (bus.ub_store) store_q.push_back(int'(bus.ub_addr));
      if (bus.tile_valid) n_tv++;
      if (bus.done) n_done++;
      if (bus.cmd_error) n_err++;
      if (bus.acc_ack) n_ack++;
      if (bus.done && bus.tile_valid) n_done_tv++;
      if (bus.busy) n_busy++;
      if (!bus.cmd_ready) ready_low = 1;
    end
    prev_load  = bus.ub_load_input;
    prev_reset = reset;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 1'b0;
    bus.cmd_base   = '0;
    bus.cmd_count  = '0;
    bus.cmd_stride = '0;
    bus.isb_ready  = 1'b0;
    bus.store_acc1 = 1'b0;
    bus.store_acc2 = 1'b0;
  endtask

  task automatic drive_rand(input int mode);
    if (mode == 0) begin
      bus.isb_ready  = 1'b1;
      bus.store_acc1 = 1'b1;
      bus.store_acc2 = 1'b1;
    end else begin
      bus.isb_ready  = ($urandom_range(0, 1) != 0);
      bus.store_acc1 = ($urandom_range(0, 3) != 0);
      bus.store_acc2 = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic op, input int base, input int count,
                         input int stride, input int mode);
    bit got, fin;
    clear_mon();
    bus.cmd_op     = op;
    bus.cmd_base   = ADDR_W'(base);
    bus.cmd_count  = CNT_W'(count);
    bus.cmd_stride = STRIDE_W'(stride);
    bus.cmd_valid  = 1'b1;
    drive_rand(mode);
    got = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.cmd_ready) begin got = 1; break; end
      cyc(); drive_rand(mode);
    end
    check("accept_ready", 64'(got), 1);
    cyc();
    bus.cmd_valid = 1'b0;
    drive_rand(mode);
    fin = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (n_done + n_err > 0) begin fin = 1; break; end
      cyc(); drive_rand(mode);
    end
    check("cmd_finished", 64'(fin), 1);
    repeat (3) begin cyc(); drive_rand(mode); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic compare(input logic op, input int base, input int stride,
                         input int exp_err, input int exp_n);
    int sq_size, oq_size;
    sq_size = (op == OP_STORE) ? store_q.size() : load_q.size();
    oq_size = (op == OP_STORE) ? load_q.size() : store_q.size();
    check("cmd_error_pulses", n_err, exp_err);
    check("done_pulses", n_done, (exp_err != 0) ? 0 : 1);
    check("strobe_count", sq_size, exp_n);
    check("other_strobes", oq_size, 0);
    for (int i = 0; i < exp_n && i < sq_size; i++) begin
      int a;
      a = (op == OP_STORE) ? store_q[i] : load_q[i];
      check("strobe_addr", a, base + i * stride);
    end
    check("tile_valid_pulses", n_tv, (op == OP_LOAD) ? exp_n : 0);
    check("acc_ack_pulses", n_ack, (op == OP_STORE) ? exp_n : 0);
    if (op == OP_LOAD && exp_n > 0) check("done_with_last_tile", n_done_tv, 1);
    if (exp_n == 0) begin
      check("ready_stays_high", 64'(ready_low), 0);
      check("never_busy", n_busy, 0);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic op;
    int   base;
    int   count;
    int   stride;
    int   exp_err;
    int   exp_n;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'(1000 + i);
    mem[30] = 32'd11; mem[31] = 32'd12; mem[32] = 32'd21; mem[33] = 32'd22;

    tbl[0]  = '{OP_LOAD,  'h1E,   1,   4, 0,  1};
    tbl[1]  = '{OP_LOAD,  0,      3,   4, 0,  3};
    tbl[2]  = '{OP_STORE, 8,      2,   4, 0,  2};
    tbl[3]  = '{OP_STORE, 60,     1,   4, 0,  1};
    tbl[4]  = '{OP_STORE, 61,     1,   4, 1,  0};
    tbl[5]  = '{OP_STORE, 0,      17,  4, 1,  0};
    tbl[6]  = '{OP_LOAD,  0,      0,   4, 0,  0};
    tbl[7]  = '{OP_LOAD,  0,      16,  4, 0, 16};
    tbl[8]  = '{OP_LOAD,  5,      2, 255, 1,  0};
    tbl[9]  = '{OP_STORE, 63,     1,   0, 1,  0};
    tbl[10] = '{OP_LOAD,  40,     3,   0, 0,  3};
    tbl[11] = '{OP_LOAD,  8191, 255, 255, 1,  0};
    tbl[12] = '{OP_STORE, 8191,   0, 255, 0,  0};
    tbl[13] = '{OP_STORE, 0,      1,   0, 0,  1};

    // reset state
    drive_idle();
    reset = 1'b1;
    repeat (3) cyc();
    check("rst_cmd_ready", 64'(bus.cmd_ready), 1);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_done", 64'(bus.done), 0);
    check("rst_cmd_error", 64'(bus.cmd_error), 0);
    check("rst_strobes", 64'({bus.ub_load_input, bus.ub_store, bus.acc_ack}), 0);
    check("rst_addr", 64'(bus.ub_addr), 0);
    check("rst_tile_valid", 64'(bus.tile_valid), 0);
    reset = 1'b0;
    mon_en = 1;
    cyc();

    for (int i = 0; i < 14; i++) begin
      run_cmd(tbl[i].op, tbl[i].base, tbl[i].count, tbl[i].stride, i % 2);
      compare(tbl[i].op, tbl[i].base, tbl[i].stride, tbl[i].exp_err, tbl[i].exp_n);
    end

    // tile data from the buffer at 0x1E
    run_cmd(OP_LOAD, 'h1E, 1, 4, 0);
    check("tile_word0", 64'(cap[0]), 11);
    check("tile_word1", 64'(cap[1]), 12);
    check("tile_word2", 64'(cap[2]), 21);
    check("tile_word3", 64'(cap[3]), 22);

    // LOAD with isb_ready low for cycles 2-3
    clear_mon();
    bus.cmd_op = OP_LOAD; bus.cmd_base = '0; bus.cmd_count = 8'd3; bus.cmd_stride = 8'd4;
    bus.cmd_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      bit en;
      cyc();
      bus.cmd_valid = 1'b0;
      en = (k != 2) && (k != 3);
      bus.isb_ready = en;
      #1;
      check("gate_load", 64'(bus.ub_load_input), (k == 1 || k == 4 || k == 5) ? 1 : 0);
      check("gate_addr", 64'(bus.ub_addr), (k == 4) ? 4 : (k == 5) ? 8 : 0);
      check("gate_done", 64'(bus.done), (k == 6) ? 1 : 0);
    end
    @(negedge clk);
    check("gate_tv_total", n_tv, 3);
    check("gate_done_total", n_done, 1);
    drive_idle();

    // STORE with scripted accumulator flags
    cyc();
    bus.cmd_op = OP_STORE; bus.cmd_base = 13'd8; bus.cmd_count = 8'd2; bus.cmd_stride = 8'd4;
    bus.cmd_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      bit fl;
      cyc();
      bus.cmd_valid = 1'b0;
      fl = (k == 3) || (k == 4) || (k == 9) || (k == 10);
      bus.store_acc1 = fl;
      bus.store_acc2 = fl;
      #1;
      check("st_store", 64'(bus.ub_store), (k == 4 || k == 10) ? 1 : 0);
      check("st_addr", 64'(bus.ub_addr), (k == 4) ? 8 : (k == 10) ? 12 : 0);
      check("st_done", 64'(bus.done), (k == 11) ? 1 : 0);
      check("st_busy", 64'(bus.busy), (k <= 10) ? 1 : 0);
    end
    drive_idle();

    // command held while busy
    cyc();
    bus.cmd_op = OP_LOAD; bus.cmd_base = '0; bus.cmd_count = 8'd4; bus.cmd_stride = 8'd4;
    bus.cmd_valid = 1'b1;
    bus.isb_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      bus.cmd_base = 13'd40; bus.cmd_count = 8'd1; bus.cmd_stride = 8'd0;
      bus.cmd_valid = (k <= 6);
      #1;
      check("hold_ready", 64'(bus.cmd_ready), (k == 6) ? 1 : 0);
      check("hold_load", 64'(bus.ub_load_input), (k <= 4 || k == 7) ? 1 : 0);
      check("hold_addr", 64'(bus.ub_addr), (k <= 4) ? 4 * (k - 1) : (k == 7) ? 40 : 0);
      check("hold_done", 64'(bus.done), (k == 5 || k == 8) ? 1 : 0);
    end
    drive_idle();

    // reset in the middle of a LOAD
    cyc();
    clear_mon();
    bus.cmd_op = OP_LOAD; bus.cmd_base = '0; bus.cmd_count = 8'd4; bus.cmd_stride = 8'd4;
    bus.cmd_valid = 1'b1;
    bus.isb_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      bus.cmd_valid = 1'b0;
      reset = (k == 3);
      #1;
      if (k <= 2) check("rl_load", 64'(bus.ub_load_input), 1);
      if (k == 4) begin
        check("rl_ready", 64'(bus.cmd_ready), 1);
        check("rl_outs", 64'({bus.ub_load_input, bus.ub_store, bus.acc_ack,
                              bus.tile_valid, bus.busy, bus.done, bus.cmd_error}), 0);
        check("rl_addr", 64'(bus.ub_addr), 0);
      end
      if (k >= 5) check("rl_no_strobe", 64'(bus.ub_load_input), 0);
    end
    @(negedge clk);
    check("rl_total_loads", load_q.size(), 3);
    drive_idle();
    cyc();

    // randomized commands against the arithmetic model
    for (int n = 0; n < 30; n++) begin
      logic  op;
      int    base, count, stride, exp_err, exp_n;
      longint last;
      op     = ($urandom_range(0, 1) != 0);
      base   = $urandom_range(0, 66);
      count  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
      stride = $urandom_range(0, 12);
      last   = longint'(base) + longint'(stride) * longint'(count - 1) + 3;
      exp_err = (count != 0 && last > MEM_DEPTH - 1) ? 1 : 0;
      exp_n   = (exp_err != 0) ? 0 : count;
      run_cmd(op, base, count, stride, 1);
      compare(op, base, stride, exp_err, exp_n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
